// File: rtl/scmi_doorbell_arbiter.sv
// rtl/scmi_doorbell_arbiter.sv - round-robin arbiter offering pending SCMI doorbell channels to one consumer
module scmi_doorbell_arbiter #(
  parameter int NumChannels = 4,
  parameter int IdWidth     = $clog2(NumChannels)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumChannels-1:0] doorbell_i,
  input  logic [NumChannels-1:0] enable_i,
  output logic                   chan_valid_o,
  output logic [IdWidth-1:0]     chan_id_o,
  input  logic                   chan_ready_i,
  output logic                   irq_o,
  output logic [NumChannels-1:0] overflow_o,
  input  logic [NumChannels-1:0] overflow_clr_i
);

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [NumChannels-1:0] r_pending;
  logic [NumChannels-1:0] r_overflow;
  logic [IdWidth-1:0]     r_rr_ptr;
  logic [IdWidth-1:0]     r_id_q;
  logic                   r_irq;

  logic [NumChannels-1:0] w_elig;
  logic [NumChannels-1:0] w_ge_mask;
  logic [NumChannels-1:0] w_sel_vec;
  logic [IdWidth-1:0]     w_pick;
  logic                   w_load;
  logic                   w_accept;
  logic [NumChannels-1:0] w_clr;
  logic [NumChannels-1:0] w_ovf_evt;
  logic [IdWidth-1:0]     w_rr_nxt;

  assign w_elig    = r_pending & enable_i;
  assign w_accept  = (r_state == S_OFFER) && chan_ready_i;
  assign w_clr     = w_accept ? (NumChannels'(1) << r_id_q) : '0;
  // A doorbell only counts as lost if the pending bit is not being consumed this cycle.
  assign w_ovf_evt = doorbell_i & r_pending & ~w_clr;
  assign w_rr_nxt  = (r_id_q == IdWidth'(NumChannels - 1)) ? '0 : r_id_q + 1'b1;

  always_comb begin
    w_ge_mask = '0;
    for (int i = 0; i < NumChannels; i++) begin
      w_ge_mask[i] = (IdWidth'(i) >= r_rr_ptr);
    end
    w_sel_vec = ((w_elig & w_ge_mask) != '0) ? (w_elig & w_ge_mask) : w_elig;
    w_pick    = '0;
    for (int i = NumChannels - 1; i >= 0; i--) begin
      if (w_sel_vec[i]) w_pick = IdWidth'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_elig != '0) begin
          w_load      = 1'b1;
          w_state_nxt = S_OFFER;
        end
      end
      S_OFFER: begin
        if (chan_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_pending  <= '0;
      r_overflow <= '0;
      r_rr_ptr   <= '0;
      r_id_q     <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= (r_pending & ~w_clr) | doorbell_i;
      r_overflow <= (r_overflow & ~overflow_clr_i) | w_ovf_evt;
      r_irq      <= |w_elig;
      if (w_load)   r_id_q   <= w_pick;
      if (w_accept) r_rr_ptr <= w_rr_nxt;
    end
  end

  assign chan_valid_o = (r_state == S_OFFER);
  assign chan_id_o    = r_id_q;
  assign irq_o        = r_irq;
  assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_scmi_doorbell_arbiter.sv
// tb/tb_scmi_doorbell_arbiter.sv - directed self-checking bench for scmi_doorbell_arbiter
module tb_scmi_doorbell_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [3:0] doorbell_i = '0;
  logic [3:0] enable_i = 4'hF;
  logic       chan_valid_o;
  logic [1:0] chan_id_o;
  logic       chan_ready_i = 1'b0;
  logic       irq_o;
  logic [3:0] overflow_o;
  logic [3:0] overflow_clr_i = '0;

  int n_checks = 0;
  int n_fail   = 0;

  scmi_doorbell_arbiter #(.NumChannels(4)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .doorbell_i     (doorbell_i),
    .enable_i       (enable_i),
    .chan_valid_o   (chan_valid_o),
    .chan_id_o      (chan_id_o),
    .chan_ready_i   (chan_ready_i),
    .irq_o          (irq_o),
    .overflow_o     (overflow_o),
    .overflow_clr_i (overflow_clr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic offer(input string tag, input logic v, input logic [1:0] id);
    check({tag, "_valid"}, 32'(chan_valid_o), 32'(v));
    if (v) check({tag, "_id"}, 32'(chan_id_o), 32'(id));
  endtask

  initial begin
    // reset values
    step(2);
    offer("rst", 1'b0, 2'd0);
    check("rst_id", 32'(chan_id_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    rst_ni = 1'b1;
    step(1);

    // single doorbell on channel 2
    doorbell_i = 4'b0100;
    step(1);
    doorbell_i = '0;
    offer("single_t1", 1'b0, 2'd0);
    step(1);
    offer("single_t2", 1'b1, 2'd2);
    check("single_t2_irq", 32'(irq_o), 32'd1);
    step(1);
    offer("single_t3", 1'b1, 2'd2);
    chan_ready_i = 1'b1;
    step(1);
    chan_ready_i = 1'b0;
    offer("single_t4", 1'b0, 2'd0);
    check("single_t4_irq", 32'(irq_o), 32'd1);
    step(1);
    check("single_t5_irq", 32'(irq_o), 32'd0);
    offer("single_t5", 1'b0, 2'd0);

    // rr_ptr is 3 here: pending {0,1} must wrap to 0 first
    doorbell_i = 4'b0011;
    step(1);
    doorbell_i = '0;
    chan_ready_i = 1'b1;
    step(1);
    offer("wrap_a", 1'b1, 2'd0);
    step(1);
    offer("wrap_gap", 1'b0, 2'd0);
    step(1);
    offer("wrap_b", 1'b1, 2'd1);
    chan_ready_i = 1'b0;
    step(1);

    // round robin from rr_ptr=0 with pending 1011, ready held
    rst_ni = 1'b0;
    step(1);
    rst_ni = 1'b1;
    step(1);
    doorbell_i = 4'b1011;
    step(1);
    doorbell_i = '0;
    chan_ready_i = 1'b1;
    offer("rr_t1", 1'b0, 2'd0);
    step(1);
    offer("rr_t2", 1'b1, 2'd0);
    step(1);
    offer("rr_t3", 1'b0, 2'd0);
    doorbell_i = 4'b0001;
    step(1);
    doorbell_i = '0;
    offer("rr_t4", 1'b1, 2'd1);
    step(1);
    offer("rr_t5", 1'b0, 2'd0);
    step(1);
    offer("rr_t6", 1'b1, 2'd3);
    step(1);
    offer("rr_t7", 1'b0, 2'd0);
    step(1);
    offer("rr_t8", 1'b1, 2'd0);
    step(1);
    offer("rr_t9", 1'b0, 2'd0);
    chan_ready_i = 1'b0;
    step(1);
    offer("rr_t10", 1'b0, 2'd0);
    check("rr_ovf", 32'(overflow_o), 32'd0);

    // overflow on channel 1
    doorbell_i = 4'b0010;
    step(1);
    step(0);
    doorbell_i = 4'b0010;
    step(1);
    doorbell_i = '0;
    check("ovf_set", 32'(overflow_o), 32'b0010);
    offer("ovf_offer", 1'b1, 2'd1);
    chan_ready_i = 1'b1;
    step(1);
    chan_ready_i = 1'b0;
    offer("ovf_acc", 1'b0, 2'd0);
    step(1);
    offer("ovf_once", 1'b0, 2'd0);
    check("ovf_sticky", 32'(overflow_o), 32'b0010);
    overflow_clr_i = 4'b0010;
    step(1);
    overflow_clr_i = '0;
    check("ovf_clr", 32'(overflow_o), 32'd0);
    doorbell_i = 4'b0010;
    step(1);
    doorbell_i = 4'b0010;
    overflow_clr_i = 4'b0010;
    step(1);
    doorbell_i = '0;
    overflow_clr_i = '0;
    check("ovf_set_wins", 32'(overflow_o), 32'b0010);
    chan_ready_i = 1'b1;
    step(1);
    chan_ready_i = 1'b0;
    overflow_clr_i = 4'b0010;
    step(1);
    overflow_clr_i = '0;
    check("ovf_clr2", 32'(overflow_o), 32'd0);

    // masked channel 3, then offer holds while enable drops
    enable_i = 4'b0111;
    doorbell_i = 4'b1000;
    step(1);
    doorbell_i = '0;
    step(3);
    offer("mask_none", 1'b0, 2'd0);
    check("mask_irq", 32'(irq_o), 32'd0);
    enable_i = 4'hF;
    step(1);
    offer("mask_on", 1'b1, 2'd3);
    check("mask_on_irq", 32'(irq_o), 32'd1);
    enable_i = 4'b0111;
    step(1);
    offer("mask_hold1", 1'b1, 2'd3);
    check("mask_hold_irq", 32'(irq_o), 32'd0);
    step(1);
    offer("mask_hold2", 1'b1, 2'd3);
    chan_ready_i = 1'b1;
    step(1);
    chan_ready_i = 1'b0;
    enable_i = 4'hF;
    offer("mask_acc", 1'b0, 2'd0);
    step(2);
    offer("mask_clear", 1'b0, 2'd0);

    // accept of id 0 collides with a new doorbell on 0
    doorbell_i = 4'b0001;
    step(1);
    doorbell_i = '0;
    step(1);
    offer("col_t2", 1'b1, 2'd0);
    chan_ready_i = 1'b1;
    doorbell_i = 4'b0001;
    step(1);
    chan_ready_i = 1'b0;
    doorbell_i = '0;
    offer("col_t3", 1'b0, 2'd0);
    check("col_ovf", 32'(overflow_o), 32'd0);
    step(1);
    offer("col_t4", 1'b1, 2'd0);
    chan_ready_i = 1'b1;
    step(1);
    chan_ready_i = 1'b0;

    // reset asserted mid-offer
    doorbell_i = 4'b0100;
    step(1);
    doorbell_i = '0;
    step(1);
    offer("rmo_pre", 1'b1, 2'd2);
    check("rmo_pre_irq", 32'(irq_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("rmo_valid", 32'(chan_valid_o), 32'd0);
    check("rmo_irq", 32'(irq_o), 32'd0);
    check("rmo_id", 32'(chan_id_o), 32'd0);
    step(1);
    rst_ni = 1'b1;
    step(3);
    offer("rmo_after", 1'b0, 2'd0);
    check("rmo_after_irq", 32'(irq_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
